// File: rtl/pll_phase_ctrl.sv
// Dynamic phase-shift sequencer and LOCK supervisor for the GW5A PLL.
// Steps each output along the shortest path and re-acquires lock on loss.
module pll_phase_ctrl #(
    parameter int NUM_CH     = 3,
    parameter int STEPS      = 64,
    parameter int PULSE_HIGH = 4,
    parameter int PULSE_GAP  = 8,
    parameter int RST_CYCLES = 16,
    parameter int LOCK_WAIT  = 4096,
    localparam int PH_W      = $clog2(STEPS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_ch,
    input  logic [PH_W-1:0] req_phase,
    output logic            done,
    output logic            req_err,
    output logic            busy,
    input  logic            pll_lock,
    output logic            pll_reset,
    output logic [2:0]      ps_sel,
    output logic            ps_dir,
    output logic            ps_pulse,
    input  logic [2:0]      rd_ch,
    output logic [PH_W-1:0] rd_phase,
    output logic            lock_lost,
    output logic            lock_timeout
);

    localparam int C1 = (PULSE_HIGH > PULSE_GAP) ? PULSE_HIGH : PULSE_GAP;
    localparam int C2 = (C1 > RST_CYCLES) ? C1 : RST_CYCLES;
    localparam int C3 = (C2 > LOCK_WAIT) ? C2 : LOCK_WAIT;
    localparam int CW = $clog2(C3 + 1);
    localparam logic [PH_W-1:0] HALF = PH_W'(STEPS / 2);

    typedef enum logic [2:0] {
        S_WAIT_LOCK,
        S_IDLE,
        S_SETUP,
        S_PULSE_H,
        S_PULSE_L,
        S_DONE,
        S_PLL_RST
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      ch_q, ch_d;
    logic [2:0]      sel_q, sel_d;
    logic            dir_q, dir_d;
    logic [PH_W-1:0] rem_q, rem_d;
    logic            err_q, err_d;
    logic            tout_q, tout_d;
    logic            step_en;
    logic            clr_en;
    logic            supervised;
    logic [PH_W-1:0] phase_q [NUM_CH];
    logic [PH_W-1:0] cur_req;
    logic [PH_W-1:0] diff;

    always_comb begin
        cur_req = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (req_ch == 3'(i)) cur_req = phase_q[i];
        end
    end

    always_comb begin
        rd_phase = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_ch == 3'(i)) rd_phase = phase_q[i];
        end
    end

    assign diff         = req_phase - cur_req;
    assign ps_sel       = sel_q;
    assign ps_dir       = dir_q;
    assign lock_timeout = tout_q;
    assign supervised   = (state_q != S_WAIT_LOCK) && (state_q != S_PLL_RST);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ch_d      = ch_q;
        sel_d     = sel_q;
        dir_d     = dir_q;
        rem_d     = rem_q;
        err_d     = err_q;
        tout_d    = tout_q;
        step_en   = 1'b0;
        clr_en    = 1'b0;
        req_ready = 1'b0;
        done      = 1'b0;
        req_err   = 1'b0;
        busy      = 1'b1;
        pll_reset = 1'b0;
        ps_pulse  = 1'b0;
        lock_lost = 1'b0;

        case (state_q)
            S_WAIT_LOCK: begin
                if (pll_lock) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(LOCK_WAIT - 1)) begin
                    tout_d  = 1'b1;
                    state_d = S_PLL_RST;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_IDLE: begin
                busy      = 1'b0;
                req_ready = pll_lock;
                if (req_valid && pll_lock) begin
                    ch_d  = req_ch;
                    err_d = 1'b0;
                    if (32'(req_ch) >= NUM_CH) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (diff == '0) begin
                        state_d = S_DONE;
                    end else begin
                        // exactly half a period advances rather than retards
                        sel_d   = req_ch;
                        dir_d   = (diff > HALF);
                        rem_d   = (diff > HALF) ? ('0 - diff) : diff;
                        state_d = S_SETUP;
                    end
                end
            end
            S_SETUP: begin
                cnt_d   = '0;
                state_d = S_PULSE_H;
            end
            S_PULSE_H: begin
                ps_pulse = 1'b1;
                if (cnt_q == CW'(PULSE_HIGH - 1)) begin
                    step_en = 1'b1;
                    rem_d   = rem_q - PH_W'(1);
                    cnt_d   = '0;
                    state_d = S_PULSE_L;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_PULSE_L: begin
                if (cnt_q == CW'(PULSE_GAP - 1)) begin
                    cnt_d   = '0;
                    state_d = (rem_q != '0) ? S_PULSE_H : S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                done    = 1'b1;
                req_err = err_q;
                state_d = S_IDLE;
            end
            S_PLL_RST: begin
                pll_reset = 1'b1;
                clr_en    = 1'b1;
                if (cnt_q == CW'(RST_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_LOCK;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_WAIT_LOCK;
            end
        endcase

        // lock loss wins over any step completing in the same cycle
        if (supervised && !pll_lock) begin
            lock_lost = 1'b1;
            ps_pulse  = 1'b0;
            step_en   = 1'b0;
            rem_d     = rem_q;
            if (state_q != S_IDLE) begin
                done    = 1'b1;
                req_err = 1'b1;
            end
            cnt_d   = '0;
            state_d = S_PLL_RST;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_WAIT_LOCK;
            cnt_q   <= '0;
            ch_q    <= '0;
            sel_q   <= '0;
            dir_q   <= 1'b0;
            rem_q   <= '0;
            err_q   <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ch_q    <= ch_d;
            sel_q   <= sel_d;
            dir_q   <= dir_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
            tout_q  <= tout_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (rst || clr_en) begin
                phase_q[i] <= '0;
            end else if (step_en && ch_q == 3'(i)) begin
                phase_q[i] <= dir_q ? phase_q[i] - PH_W'(1)
                                    : phase_q[i] + PH_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Directed bench for pll_phase_ctrl: stepping, wrap, tie, bad channel,
// lock loss and lock timeout, with hand-computed expectations.
module tb_pll_phase_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_ch;
    logic [5:0] req_phase;
    logic       done;
    logic       req_err;
    logic       busy;
    logic       pll_lock;
    logic       pll_reset;
    logic [2:0] ps_sel;
    logic       ps_dir;
    logic       ps_pulse;
    logic [2:0] rd_ch;
    logic [5:0] rd_phase;
    logic       lock_lost;
    logic       lock_timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pll_phase_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_ch(req_ch), .req_phase(req_phase),
        .done(done), .req_err(req_err), .busy(busy),
        .pll_lock(pll_lock), .pll_reset(pll_reset),
        .ps_sel(ps_sel), .ps_dir(ps_dir), .ps_pulse(ps_pulse),
        .rd_ch(rd_ch), .rd_phase(rd_phase),
        .lock_lost(lock_lost), .lock_timeout(lock_timeout)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic run_req(
        input  logic [2:0] ch,
        input  logic [5:0] ph,
        output int         lat,
        output int         npulse,
        output int         nhigh,
        output int         err,
        output int         dir_seen,
        output int         sel_seen,
        output int         first_ph
    );
        logic prev;
        lat = 0; npulse = 0; nhigh = 0; err = -1;
        dir_seen = -1; sel_seen = -1; first_ph = -1;
        prev = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_ch    = ch;
        req_phase = ph;
        rd_ch     = ch;
        #1 check("ready", int'(req_ready), 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int i = 1; i <= 1000; i++) begin
            @(negedge clk);
            if (ps_pulse) begin
                nhigh++;
                if (!prev) begin
                    npulse++;
                    dir_seen = int'(ps_dir);
                    sel_seen = int'(ps_sel);
                end
            end
            if (prev && !ps_pulse && npulse == 1) first_ph = int'(rd_phase);
            prev = ps_pulse;
            if (done) begin
                lat = i;
                err = int'(req_err);
                break;
            end
        end
    endtask

    int lat, np, nh, er, dr, sl, fp, n;
    logic seen;

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_ch = '0; req_phase = '0;
        rd_ch = '0; pll_lock = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_ready", int'(req_ready), 0);
        check("rst_busy", int'(busy), 1);
        check("rst_done", int'(done), 0);
        check("rst_pllrst", int'(pll_reset), 0);
        check("rst_pulse", int'(ps_pulse), 0);
        check("rst_sel", int'(ps_sel), 0);
        check("rst_tout", int'(lock_timeout), 0);
        check("rst_phase", int'(rd_phase), 0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("idle_busy", int'(busy), 0);

        // ch1 0 -> 3: advance by 3
        run_req(3'd1, 6'd3, lat, np, nh, er, dr, sl, fp);
        check("t1_lat", lat, 38);
        check("t1_err", er, 0);
        check("t1_pulses", np, 3);
        check("t1_high", nh, 12);
        check("t1_dir", dr, 0);
        check("t1_sel", sl, 1);
        check("t1_first", fp, 1);
        rd_ch = 3'd1; #1 check("t1_phase", int'(rd_phase), 3);
        rd_ch = 3'd0; #1 check("t1_ch0", int'(rd_phase), 0);

        // ch0 0 -> 60: retard by 4 through the wrap
        run_req(3'd0, 6'd60, lat, np, nh, er, dr, sl, fp);
        check("t2_lat", lat, 50);
        check("t2_pulses", np, 4);
        check("t2_dir", dr, 1);
        check("t2_sel", sl, 0);
        check("t2_wrap", fp, 63);
        #1 check("t2_phase", int'(rd_phase), 60);

        // ch2 0 -> 32: tie advances 32 steps
        run_req(3'd2, 6'd32, lat, np, nh, er, dr, sl, fp);
        check("t3_lat", lat, 386);
        check("t3_pulses", np, 32);
        check("t3_dir", dr, 0);
        check("t3_sel", sl, 2);
        #1 check("t3_phase", int'(rd_phase), 32);
        run_req(3'd2, 6'd32, lat, np, nh, er, dr, sl, fp);
        check("t3z_lat", lat, 1);
        check("t3z_pulses", np, 0);
        check("t3z_err", er, 0);

        // invalid channel
        run_req(3'd5, 6'd7, lat, np, nh, er, dr, sl, fp);
        check("t4_lat", lat, 1);
        check("t4_err", er, 1);
        check("t4_pulses", np, 0);
        #1 check("t4_rdbad", int'(rd_phase), 0);

        // lock loss during 2nd of 5 pulses (ch1 3 -> 8)
        @(negedge clk);
        req_valid = 1'b1; req_ch = 3'd1; req_phase = 6'd8; rd_ch = 3'd1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        np = 0; seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ps_pulse && !seen) np++;
            seen = ps_pulse;
            if (np == 2 && ps_pulse) break;
        end
        check("t5_reach", np, 2);
        check("t5_ph_pre", int'(rd_phase), 4);
        pll_lock = 1'b0;
        #1;
        check("t5_pulse0", int'(ps_pulse), 0);
        check("t5_lost", int'(lock_lost), 1);
        check("t5_done", int'(done), 1);
        check("t5_err", int'(req_err), 1);
        @(posedge clk);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!pll_reset) break;
            n++;
            if (n == 2) begin
                for (int c = 0; c < 3; c++) begin
                    rd_ch = 3'(c);
                    #1 check("t5_clr", int'(rd_phase), 0);
                end
            end
        end
        check("t5_rstlen", n, 16);
        check("t5_lost_rst", int'(lock_lost), 0);
        pll_lock = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t5_ready", int'(req_ready), 1);
        check("t5_tout", int'(lock_timeout), 0);

        // lock never arrives after reset
        pll_lock = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4095) @(posedge clk);
        @(negedge clk);
        check("t6_tout_pre", int'(lock_timeout), 0);
        @(posedge clk);
        @(negedge clk);
        check("t6_tout", int'(lock_timeout), 1);
        check("t6_pllrst", int'(pll_reset), 1);
        n = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!pll_reset) break;
            n++;
        end
        check("t6_rstlen", n, 16);
        n = 1;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (pll_reset) break;
            n++;
        end
        check("t6_wait", n, 4096);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!pll_reset) break;
        end
        check("t6_rstend", int'(pll_reset), 0);
        pll_lock = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t6_ready", int'(req_ready), 1);
        check("t6_sticky", int'(lock_timeout), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
